alu_8bit: RTL and testbench

Registered 8-bit arithmetic/logic unit with a 4-bit operation select and a carry/flag output. It takes two 8-bit operands and produces one 8-bit result plus one status bit per clock. Used as the datapath execute stage in the 8-bit processor designs and as a standalone FPGA demo block on Zynq-7000.

---
 rtl/alu8_pkg.sv | 23 ++
 rtl/alu8_divider.sv | 35 +++
 rtl/alu_8bit.sv | 97 +++++++++
 tb/tb_alu_8bit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// rtl/alu8_pkg.sv - Opcode encodings and datapath width shared by the 8-bit ALU.
package alu8_pkg;

    localparam int ALU8_WIDTH = 8;

    localparam logic [3:0] ALU_ADD          = 4'h0;
    localparam logic [3:0] ALU_SUB          = 4'h1;
    localparam logic [3:0] ALU_MUL          = 4'h2;
    localparam logic [3:0] ALU_DIV          = 4'h3;
    localparam logic [3:0] ALU_LSHIFT       = 4'h4;
    localparam logic [3:0] ALU_RSHIFT       = 4'h5;
    localparam logic [3:0] ALU_ROTATE_LEFT  = 4'h6;
    localparam logic [3:0] ALU_ROTATE_RIGHT = 4'h7;
    localparam logic [3:0] ALU_AND          = 4'h8;
    localparam logic [3:0] ALU_OR           = 4'h9;
    localparam logic [3:0] ALU_XOR          = 4'hA;
    localparam logic [3:0] ALU_NOR          = 4'hB;
    localparam logic [3:0] ALU_NAND         = 4'hC;
    localparam logic [3:0] ALU_XNOR         = 4'hD;
    localparam logic [3:0] ALU_GREATER      = 4'hE;
    localparam logic [3:0] ALU_EQUAL        = 4'hF;

endpackage

// File: rtl/alu8_divider.sv
// rtl/alu8_divider.sv - Single-cycle combinational restoring divider for unsigned 8-bit operands.
module alu8_divider
    import alu8_pkg::*;
(
    input  logic [ALU8_WIDTH-1:0] dividend,
    input  logic [ALU8_WIDTH-1:0] divisor,
    output logic [ALU8_WIDTH-1:0] quotient,
    output logic                  div_by_zero
);

    logic [ALU8_WIDTH:0]   rem;
    logic [ALU8_WIDTH:0]   trial;
    logic [ALU8_WIDTH-1:0] quot;

    // Unrolled into one subtract/restore row per quotient bit, MSB first.
    always_comb begin
        rem   = '0;
        trial = '0;
        quot  = '0;
        for (int i = ALU8_WIDTH - 1; i >= 0; i--) begin
            rem   = {rem[ALU8_WIDTH-1:0], dividend[i]};
            trial = rem - {1'b0, divisor};
            if (!trial[ALU8_WIDTH]) begin
                rem     = trial;
                quot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        div_by_zero = (divisor == '0);
        quotient    = div_by_zero ? '1 : quot;
    end

endmodule

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - Registered 8-bit ALU, 16 opcodes, one-cycle latency; divider enabled by ALU8_DIV_EN.
module alu_8bit
    import alu8_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU8_WIDTH-1:0] A,
    input  logic [ALU8_WIDTH-1:0] B,
    input  logic [3:0]            alu_sel,
    output logic [ALU8_WIDTH-1:0] alu_out,
    output logic                  c_out
);

    logic [ALU8_WIDTH:0]       sum;
    logic [2*ALU8_WIDTH-1:0]   prod;
    logic [ALU8_WIDTH-1:0]     div_quot;
    logic                      div_zero;
    logic [ALU8_WIDTH-1:0]     alu_out_d, alu_out_q;
    logic                      c_out_d, c_out_q;

`ifdef ALU8_DIV_EN
    alu8_divider u_divider (
        .dividend    (A),
        .divisor     (B),
        .quotient    (div_quot),
        .div_by_zero (div_zero)
    );
`else
    // Without the divider opcode 3 collapses to a zero result and clear flag.
    assign div_quot = '0;
    assign div_zero = 1'b0;
`endif

    always_comb begin
        sum  = {1'b0, A} + {1'b0, B};
        prod = {{ALU8_WIDTH{1'b0}}, A} * {{ALU8_WIDTH{1'b0}}, B};
    end

    always_comb begin
        alu_out_d = '0;
        c_out_d   = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                alu_out_d = sum[ALU8_WIDTH-1:0];
                c_out_d   = sum[ALU8_WIDTH];
            end
            ALU_SUB: begin
                alu_out_d = A - B;
                c_out_d   = (A < B);
            end
            ALU_MUL: begin
                alu_out_d = prod[ALU8_WIDTH-1:0];
                c_out_d   = |prod[2*ALU8_WIDTH-1:ALU8_WIDTH];
            end
            ALU_DIV: begin
                alu_out_d = div_quot;
                c_out_d   = div_zero;
            end
            ALU_LSHIFT: begin
                alu_out_d = {A[ALU8_WIDTH-2:0], 1'b0};
                c_out_d   = A[ALU8_WIDTH-1];
            end
            ALU_RSHIFT: begin
                alu_out_d = {1'b0, A[ALU8_WIDTH-1:1]};
                c_out_d   = A[0];
            end
            ALU_ROTATE_LEFT:  alu_out_d = {A[ALU8_WIDTH-2:0], A[ALU8_WIDTH-1]};
            ALU_ROTATE_RIGHT: alu_out_d = {A[0], A[ALU8_WIDTH-1:1]};
            ALU_AND:          alu_out_d = A & B;
            ALU_OR:           alu_out_d = A | B;
            ALU_XOR:          alu_out_d = A ^ B;
            ALU_NOR:          alu_out_d = ~(A | B);
            ALU_NAND:         alu_out_d = ~(A & B);
            ALU_XNOR:         alu_out_d = ~(A ^ B);
            ALU_GREATER:      alu_out_d = {{(ALU8_WIDTH-1){1'b0}}, (A > B)};
            ALU_EQUAL:        alu_out_d = {{(ALU8_WIDTH-1){1'b0}}, (A == B)};
            default: begin
                alu_out_d = '0;
                c_out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            c_out_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            c_out_q   <= c_out_d;
        end
    end

    assign alu_out = alu_out_q;
    assign c_out   = c_out_q;

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - Directed and randomized checks of alu_8bit against an arithmetic reference model.
module tb_alu_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       c_out;

    int total  = 0;
    int passed = 0;
    int failed = 0;

`ifdef ALU8_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .c_out   (c_out)
    );

    always #5 clk = ~clk;

    // Returns {carry, result} using integer arithmetic on the operation rules.
    function automatic logic [8:0] model(input int sel, input int a, input int b);
        int r;
        int c;
        r = 0;
        c = 0;
        case (sel)
            0:  begin r = (a + b) % 256; c = (a + b > 255); end
            1:  begin r = (a - b + 256) % 256; c = (a < b); end
            2:  begin r = (a * b) % 256; c = (a * b > 255); end
            3:  begin
                    if (DIV_EN && b == 0) begin r = 255; c = 1; end
                    else if (DIV_EN)      begin r = a / b; c = 0; end
                    else                  begin r = 0; c = 0; end
                end
            4:  begin r = (a * 2) % 256; c = (a >= 128); end
            5:  begin r = a / 2; c = a % 2; end
            6:  r = (a * 2) % 256 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        model = {c[0], r[7:0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        A = a;
        B = b;
        alu_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic run_checked(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sel, input logic [7:0] exp_out, input logic exp_c);
        step(a, b, sel);
        check({tag, "_out"}, alu_out, exp_out);
        check({tag, "_c"}, {7'd0, c_out}, {7'd0, exp_c});
    endtask

    logic [7:0] sweep_exp [16];
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic [3:0] rs;

    initial begin
        sweep_exp = '{8'd15, 8'd5, 8'd50, 8'd0, 8'd20, 8'd5, 8'd20, 8'd5,
                      8'd0, 8'd15, 8'd15, 8'd240, 8'd255, 8'd240, 8'd1, 8'd0};
        if (DIV_EN) sweep_exp[3] = 8'd2;

        rst = 1'b1;
        step(8'd10, 8'd5, 4'd0);
        check("reset_out", alu_out, 8'h00);
        check("reset_c", {7'd0, c_out}, 8'h00);
        rst = 1'b0;
        run_checked("post_reset_add", 8'd10, 8'd5, 4'd0, 8'd15, 1'b0);

        for (int s = 0; s < 16; s++) begin
            run_checked($sformatf("sweep_sel%0d", s), 8'd10, 8'd5, s[3:0], sweep_exp[s], 1'b0);
        end

        run_checked("add_carry", 8'd200, 8'd100, 4'd0, 8'd44, 1'b1);
        run_checked("sub_borrow", 8'd5, 8'd10, 4'd1, 8'd251, 1'b1);
        run_checked("mul_ovf", 8'd20, 8'd20, 4'd2, 8'd144, 1'b1);
        run_checked("lshift", 8'h81, 8'h00, 4'd4, 8'h02, 1'b1);
        run_checked("rshift", 8'h81, 8'h00, 4'd5, 8'h40, 1'b1);
        run_checked("rol", 8'h81, 8'h00, 4'd6, 8'h03, 1'b0);
        run_checked("ror", 8'h81, 8'h00, 4'd7, 8'hC0, 1'b0);
        run_checked("div_zero", 8'd7, 8'd0, 4'd3, DIV_EN ? 8'hFF : 8'h00, DIV_EN);
        run_checked("gt_eq", 8'd33, 8'd33, 4'd14, 8'd0, 1'b0);
        run_checked("eq_eq", 8'd33, 8'd33, 4'd15, 8'd1, 1'b0);
        run_checked("gt_big", 8'd34, 8'd33, 4'd14, 8'd1, 1'b0);
        run_checked("eq_big", 8'd34, 8'd33, 4'd15, 8'd0, 1'b0);

        // Reset mid-stream discards the op sampled on the same edge.
        run_checked("pre_midreset", 8'd255, 8'd255, 4'd0, 8'd254, 1'b1);
        rst = 1'b1;
        step(8'd255, 8'd255, 4'd0);
        check("midreset_out", alu_out, 8'h00);
        check("midreset_c", {7'd0, c_out}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rs = 4'($urandom);
            m  = model(int'(rs), int'(ra), int'(rb));
            run_checked($sformatf("rand%0d_sel%0d_a%0h_b%0h", i, rs, ra, rb), ra, rb, rs, m[7:0], m[8]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
